// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and default sizing for the sequential divider.
package div_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 5;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration (shift {A,Q}, trial subtract, restore on borrow).
module div_step #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] q_i,
  input  logic [W-1:0] m_i,
  output logic [W-1:0] a_o,
  output logic [W-1:0] q_o
);
  logic [W:0] a_sh;
  logic [W:0] t;
  // A never reaches M after a step, so its top bit is always 0 and only W bits are stored
  always_comb begin
    a_sh = {a_i, q_i[W-1]};
    t    = a_sh - {1'b0, m_i};
    a_o  = t[W] ? a_sh[W-1:0] : t[W-1:0];
    q_o  = {q_i[W-2:0], ~t[W]};
  end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: sequential unsigned restoring divider, one iteration per clock,
// results with a one-cycle done pulse; divide-by-zero short-circuits to DONE.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  state_t           state_q;
  logic [WIDTH-1:0] a_q, a_d, q_q, q_d, m_q, quot_q, rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q, dbz_q;
  div_step #(.W(WIDTH)) u_step (
    .a_i(a_q),
    .q_i(q_q),
    .m_i(m_q),
    .a_o(a_d),
    .q_o(q_d)
  );
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          if (divisor == '0) begin
            quot_q  <= '1;
            rem_q   <= dividend;
            dbz_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            m_q     <= divisor;
            q_q     <= dividend;
            a_q     <= '0;
            cnt_q   <= CNT_W'(WIDTH);
            dbz_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          a_q   <= a_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            quot_q  <= q_d;
            rem_q   <= a_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider; expectations queued at drive time,
// popped and compared at each done pulse.
module tb_seq_divider;
  localparam int W = 16;
  logic         clk = 1'b0;
  logic         clr_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  typedef struct {
    logic [W-1:0] a, b, q, r;
    logic         z;
  } exp_t;
  exp_t sb[$];
  int n_tests = 0;
  int n_fail = 0;
  seq_divider #(.WIDTH(W), .CNT_W(5)) dut (
    .clk(clk),
    .clr_n(clr_n),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Called at a negedge; returns at the done negedge when tog is set (so the next
  // request lands in DONE), otherwise one cycle later back in IDLE.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit tog,
                       input int exp_wait);
    exp_t e;
    int w, n;
    logic [31:0] p;
    e.a = a;
    e.b = b;
    e.z = (b == '0);
    e.q = e.z ? '1 : a / b;
    e.r = e.z ? a : a % b;
    sb.push_back(e);
    start = 1'b1;
    dividend = a;
    divisor = b;
    w = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      w++;
    end while (!busy && !done && w < 6);
    chk("accept_wait", w, exp_wait);
    if (!tog) start = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      chk("busy_calc", busy, 1);
      if (tog) begin
        start = 1'($urandom);
        dividend = W'($urandom);
        divisor = W'($urandom);
      end
      @(negedge clk);
      n++;
    end
    chk("busy_done_excl", busy, 0);
    chk("done_latency", n, e.z ? 1 : W + 1);
    e = sb.pop_front();
    chk("quotient", quotient, e.q);
    chk("remainder", remainder, e.r);
    chk("div_by_zero", div_by_zero, e.z);
    if (!e.z) begin
      p = quotient * e.b + remainder;
      chk("identity", p, e.a);
      chk("rem_lt_div", remainder < e.b, 1);
    end
    if (!tog) begin
      @(negedge clk);
      chk("done_pulse", done, 0);
      chk("hold_q", quotient, e.q);
    end
  endtask
  initial begin
    logic [W-1:0] ra, rb;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    clr_n = 1'b1;
    @(negedge clk);
    do_op(16'd100, 16'd7, 1'b0, 1);
    repeat (3) @(negedge clk);
    chk("hold_idle_q", quotient, 14);
    chk("hold_idle_r", remainder, 2);
    do_op(16'hFFFF, 16'd1, 1'b0, 1);
    do_op(16'd3, 16'd10, 1'b0, 1);
    do_op(16'd5, 16'd0, 1'b0, 1);
    do_op(16'd9, 16'd3, 1'b0, 1);
    do_op(16'd1000, 16'd33, 1'b1, 1);
    do_op(16'd9, 16'd3, 1'b0, 2);
    // asynchronous reset in the middle of an iteration
    start = 1'b1;
    dividend = 16'd50000;
    divisor = 16'd123;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #3 clr_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_q", quotient, 0);
    chk("arst_r", remainder, 0);
    chk("arst_dbz", div_by_zero, 0);
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    do_op(16'd50000, 16'd123, 1'b0, 1);
    for (int i = 0; i < 2000; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 19) == 0) ? '0 : W'($urandom);
      do_op(ra, rb, 1'b0, 1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
